// File: rtl/edp_mulstep.sv
// Iterative one-bit-per-clock multiply/divide sequencer for the EBOX data path.
// UMUL/SMUL shift-add on magnitudes with final sign fix-up; UDIV restoring divide.
module edp_mulstep #(
    parameter int WIDTH = 36,
    parameter int CNT_W = 6
) (
    input  logic             eboxClk,
    input  logic             eboxReset,
    input  logic             start,
    input  logic             abort,
    input  logic [1:0]       op,
    input  logic [0:WIDTH-1] opA,
    input  logic [0:WIDTH-1] opB,
    output logic             busy,
    output logic             done,
    output logic             divByZero,
    output logic [0:WIDTH-1] resHi,
    output logic [0:WIDTH-1] resLo,
    output logic [1:0]       o_dbg_state
);

    // Handshake: start is sampled only in IDLE or DONE; busy is high for the
    // WIDTH step cycles; done pulses for exactly one cycle with results valid;
    // abort in RUN returns to IDLE without done and leaves the results alone.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0]       OP_SMUL  = 2'b01;
    localparam logic [1:0]       OP_UDIV  = 2'b10;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nx;
    logic             r_is_div;
    logic             r_neg;
    logic             r_dbz;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mq;
    logic [WIDTH-1:0] r_res_hi;
    logic [WIDTH-1:0] r_res_lo;

    logic [WIDTH-1:0]   w_a_in;
    logic [WIDTH-1:0]   w_b_in;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic               w_is_smul;
    logic               w_dbz_start;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_rem_sh;
    logic               w_q_bit;
    logic [WIDTH-1:0]   w_div_acc;
    logic [WIDTH-1:0]   w_acc_nx;
    logic [WIDTH-1:0]   w_mq_nx;
    logic [2*WIDTH-1:0] w_full;
    logic [2*WIDTH-1:0] w_final;

    assign w_a_in      = opA;
    assign w_b_in      = opB;
    assign w_is_smul   = (op == OP_SMUL);
    assign w_dbz_start = (op == OP_UDIV) && (w_b_in == '0);
    // Negating the most-negative value yields 2**(WIDTH-1), which still fits unsigned.
    assign w_a_mag     = (w_is_smul && w_a_in[WIDTH-1]) ? -w_a_in : w_a_in;
    assign w_b_mag     = (w_is_smul && w_b_in[WIDTH-1]) ? -w_b_in : w_b_in;

    // Multiply step: conditionally add multiplicand, then shift {acc,mq} right.
    assign w_sum     = {1'b0, r_acc} + (r_mq[0] ? {1'b0, r_b} : '0);
    // Divide step: shift {acc,mq} left, trial-subtract divisor, restore on borrow.
    assign w_rem_sh  = {r_acc, r_mq[WIDTH-1]};
    assign w_q_bit   = (w_rem_sh >= {1'b0, r_b});
    assign w_div_acc = w_q_bit ? (w_rem_sh[WIDTH-1:0] - r_b) : w_rem_sh[WIDTH-1:0];

    assign w_acc_nx = r_is_div ? w_div_acc : w_sum[WIDTH:1];
    assign w_mq_nx  = r_is_div ? {r_mq[WIDTH-2:0], w_q_bit} : {w_sum[0], r_mq[WIDTH-1:1]};
    assign w_full   = {w_acc_nx, w_mq_nx};
    assign w_final  = r_neg ? -w_full : w_full;

    always_ff @(posedge eboxClk) begin
        if (eboxReset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_nx = w_dbz_start ? ST_DONE : ST_RUN;
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    w_state_nx = ST_IDLE;
                end else if (r_cnt == CNT_ONE) begin
                    w_state_nx = ST_DONE;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge eboxClk) begin
        if (eboxReset) begin
            r_is_div <= 1'b0;
            r_neg    <= 1'b0;
            r_dbz    <= 1'b0;
            r_cnt    <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_mq     <= '0;
            r_res_hi <= '0;
            r_res_lo <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        if (w_dbz_start) begin
                            r_dbz    <= 1'b1;
                            r_res_hi <= w_a_in;
                            r_res_lo <= '1;
                        end else begin
                            r_dbz    <= 1'b0;
                            r_is_div <= (op == OP_UDIV);
                            r_neg    <= w_is_smul && (w_a_in[WIDTH-1] ^ w_b_in[WIDTH-1]);
                            r_acc    <= '0;
                            r_cnt    <= CNT_INIT;
                            if (op == OP_UDIV) begin
                                r_b  <= w_b_in;
                                r_mq <= w_a_in;
                            end else begin
                                r_b  <= w_a_mag;
                                r_mq <= w_b_mag;
                            end
                        end
                    end
                end
                ST_RUN: begin
                    if (!abort) begin
                        r_acc <= w_acc_nx;
                        r_mq  <= w_mq_nx;
                        r_cnt <= r_cnt - CNT_ONE;
                        if (r_cnt == CNT_ONE) begin
                            r_res_hi <= w_final[2*WIDTH-1:WIDTH];
                            r_res_lo <= w_final[WIDTH-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = (r_state == ST_RUN);
    assign done        = (r_state == ST_DONE);
    assign divByZero   = r_dbz;
    assign resHi       = r_res_hi;
    assign resLo       = r_res_lo;
    assign o_dbg_state = r_state;

endmodule
